// File: rtl/instr_fetch_stage.sv
// Fetch-stage controller: drives the PC register, runs the variable-latency imem
// req/ack handshake, and owns the IF/ID register including a one-entry skid buffer.
`timescale 1ns/1ps
module instr_fetch_stage #(
  parameter int             N   = 64,
  parameter int             IW  = 32,
  parameter logic [IW-1:0]  NOP = IW'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [N-1:0]  o_pc_next,
  output logic          o_pc_en,
  output logic          o_imem_req,
  output logic [N-1:0]  o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [IW-1:0] i_imem_rdata,
  input  logic          i_flush,
  input  logic [N-1:0]  i_flush_target,
  input  logic          i_stall,
  output logic          o_id_valid,
  output logic [N-1:0]  o_id_pc,
  output logic [IW-1:0] o_id_instr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALL, S_DROP} state_t;

  state_t        r_state;
  logic [N-1:0]  r_addr;
  logic [N-1:0]  r_redir;
  logic [N-1:0]  r_buf_pc;
  logic [IW-1:0] r_buf_instr;
  logic          r_id_valid;
  logic [N-1:0]  r_id_pc;
  logic [IW-1:0] r_id_instr;

  state_t        w_state_nxt;
  logic [N-1:0]  w_addr_nxt;
  logic [N-1:0]  w_redir_nxt;
  logic [N-1:0]  w_addr_inc;
  logic [N-1:0]  w_buf_inc;
  logic          w_buf_load;
  logic          w_id_load;
  logic          w_id_kill;
  logic [N-1:0]  w_id_pc;
  logic [IW-1:0] w_id_instr;
  logic          w_pc_en;
  logic [N-1:0]  w_pc_next;

  assign w_addr_inc = r_addr + N'(4);
  assign w_buf_inc  = r_buf_pc + N'(4);

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_redir_nxt = r_redir;
    w_buf_load  = 1'b0;
    w_id_load   = 1'b0;
    w_id_kill   = 1'b0;
    w_id_pc     = r_addr;
    w_id_instr  = i_imem_rdata;
    w_pc_en     = 1'b0;
    w_pc_next   = r_addr;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (i_flush) begin
          w_pc_en    = 1'b1;
          w_pc_next  = i_flush_target;
          w_addr_nxt = i_flush_target;
          w_id_kill  = 1'b1;
        end
      end
      S_REQ: begin
        if (i_flush) begin
          w_pc_en   = 1'b1;
          w_pc_next = i_flush_target;
          w_id_kill = 1'b1;
          if (i_imem_ack) begin
            w_addr_nxt = i_flush_target;
          end else begin
            // Old transaction still in flight: remember the target until it lands.
            w_redir_nxt = i_flush_target;
            w_state_nxt = S_DROP;
          end
        end else if (i_imem_ack) begin
          if (i_stall) begin
            w_buf_load  = 1'b1;
            w_state_nxt = S_STALL;
          end else begin
            w_id_load  = 1'b1;
            w_pc_en    = 1'b1;
            w_pc_next  = w_addr_inc;
            w_addr_nxt = w_addr_inc;
          end
        end
      end
      S_STALL: begin
        if (i_flush) begin
          w_pc_en     = 1'b1;
          w_pc_next   = i_flush_target;
          w_addr_nxt  = i_flush_target;
          w_id_kill   = 1'b1;
          w_state_nxt = S_REQ;
        end else if (!i_stall) begin
          w_id_load   = 1'b1;
          w_id_pc     = r_buf_pc;
          w_id_instr  = r_buf_instr;
          w_pc_en     = 1'b1;
          w_pc_next   = w_buf_inc;
          w_addr_nxt  = w_buf_inc;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (i_flush) begin
          w_pc_en   = 1'b1;
          w_pc_next = i_flush_target;
          w_id_kill = 1'b1;
          if (i_imem_ack) begin
            w_addr_nxt  = i_flush_target;
            w_state_nxt = S_REQ;
          end else begin
            w_redir_nxt = i_flush_target;
          end
        end else if (i_imem_ack) begin
          w_addr_nxt  = r_redir;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_redir    <= '0;
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_instr <= NOP;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_redir <= w_redir_nxt;
      if (w_id_kill) begin
        r_id_valid <= 1'b0;
        r_id_instr <= NOP;
      end else if (w_id_load) begin
        r_id_valid <= 1'b1;
        r_id_pc    <= w_id_pc;
        r_id_instr <= w_id_instr;
      end
    end
  end

  // Skid buffer only holds data; its contents are meaningful only in S_STALL.
  always_ff @(posedge clk) begin
    if (w_buf_load) begin
      r_buf_pc    <= r_addr;
      r_buf_instr <= i_imem_rdata;
    end
  end

  assign o_pc_en     = w_pc_en & ~rst;
  assign o_pc_next   = w_pc_next;
  assign o_imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
  assign o_imem_addr = r_addr;
  assign o_id_valid  = r_id_valid;
  assign o_id_pc     = r_id_pc;
  assign o_id_instr  = r_id_instr;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios with literal expectations plus
// randomized traffic against a flag-based reference model of fetch behaviour.
`timescale 1ns/1ps
module tb_instr_fetch_stage;

  localparam logic [31:0] NOPV = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [63:0] pc_next;
  logic        pc_en;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic [63:0] flush_target;
  logic        stall;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  instr_fetch_stage #(.N(64), .IW(32), .NOP(NOPV)) dut (
    .clk(clk), .rst(rst),
    .o_pc_next(pc_next), .o_pc_en(pc_en),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .i_flush(flush), .i_flush_target(flush_target), .i_stall(stall),
    .o_id_valid(id_valid), .o_id_pc(id_pc), .o_id_instr(id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: fetch activity described by flags rather than a state code.
  logic        m_started;   // first request issued after reset
  logic        m_held;      // a returned instruction waits in the skid buffer
  logic        m_drop;      // in-flight fetch belongs to a squashed path
  logic [63:0] m_addr, m_redir, m_bpc;
  logic [31:0] m_binstr;
  logic        m_v;
  logic [63:0] m_pc;
  logic [31:0] m_ins;
  logic        exp_en;
  logic [63:0] exp_nxt;
  logic        obs_en;
  logic [63:0] obs_nxt;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return 32'hA500_0000 ^ a[31:0] ^ {a[63:48], 16'h0};
  endfunction

  task automatic kill_id();
    m_v = 1'b0;
    m_ins = NOPV;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input logic r, input logic a, input logic f, input logic s,
                             input logic [63:0] t, input logic [31:0] d);
    rst = r; imem_ack = a; flush = f; stall = s; flush_target = t; imem_rdata = d;
    exp_en = 1'b0;
    exp_nxt = '0;
    if (r) begin
      m_started = 1'b0; m_held = 1'b0; m_drop = 1'b0;
      m_addr = '0; m_redir = '0; m_v = 1'b0; m_pc = '0; m_ins = NOPV;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (f) begin exp_en = 1'b1; exp_nxt = t; m_addr = t; kill_id(); end
    end else if (m_held) begin
      if (f) begin
        exp_en = 1'b1; exp_nxt = t; m_addr = t; m_held = 1'b0; kill_id();
      end else if (!s) begin
        m_v = 1'b1; m_pc = m_bpc; m_ins = m_binstr;
        exp_en = 1'b1; exp_nxt = m_bpc + 64'd4; m_addr = m_bpc + 64'd4; m_held = 1'b0;
      end
    end else if (m_drop) begin
      if (f) begin exp_en = 1'b1; exp_nxt = t; kill_id(); end
      if (a) begin m_addr = f ? t : m_redir; m_drop = 1'b0; end
      else if (f) m_redir = t;
    end else begin
      if (f) begin
        exp_en = 1'b1; exp_nxt = t; kill_id();
        if (a) m_addr = t;
        else begin m_redir = t; m_drop = 1'b1; end
      end else if (a && s) begin
        m_bpc = m_addr; m_binstr = d; m_held = 1'b1;
      end else if (a) begin
        m_v = 1'b1; m_pc = m_addr; m_ins = d;
        exp_en = 1'b1; exp_nxt = m_addr + 64'd4; m_addr = m_addr + 64'd4;
      end
    end
    #1;
    obs_en = pc_en;
    obs_nxt = pc_next;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 64'h40, 32'hDEAD_BEEF);
    n_chk++; if (obs_en !== 1'b0) begin n_err++; $display("FAIL rst_pc_en got=%0b want=0", obs_en); end
    n_chk++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0b want=0", imem_req); end
    n_chk++; if (imem_addr !== 64'h0) begin n_err++; $display("FAIL rst_addr got=%0h want=0", imem_addr); end
    n_chk++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid got=%0b want=0", id_valid); end
    n_chk++; if (id_pc !== 64'h0) begin n_err++; $display("FAIL rst_id_pc got=%0h want=0", id_pc); end
    n_chk++; if (id_instr !== NOPV) begin n_err++; $display("FAIL rst_id_instr got=%0h want=%0h", id_instr, NOPV); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL idle_to_req got=%0b/%0h want=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (imem_addr !== 64'(4 * k) || imem_req !== 1'b1) begin
        n_err++; $display("FAIL b2b_addr%0d got=%0h want=%0h", k, imem_addr, 4 * k); end
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'(4 * k)));
      n_chk++; if (obs_en !== 1'b1 || obs_nxt !== 64'(4 * k + 4)) begin
        n_err++; $display("FAIL b2b_pc%0d got=%0b/%0h want=1/%0h", k, obs_en, obs_nxt, 4 * k + 4); end
      n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'(4 * k) || id_instr !== mem_f(64'(4 * k))) begin
        n_err++; $display("FAIL b2b_id%0d got=%0b/%0h/%0h want=1/%0h", k, id_valid, id_pc, id_instr, 4 * k); end
    end
  endtask

  task automatic test_latency3();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      n_chk++; if (obs_en !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0 || id_valid !== 1'b0) begin
        n_err++; $display("FAIL lat3_wait%0d got en=%0b req=%0b addr=%0h v=%0b want 0/1/0/0", k, obs_en, imem_req, imem_addr, id_valid); end
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h0));
    n_chk++; if (obs_en !== 1'b1 || id_valid !== 1'b1 || id_pc !== 64'h0 || imem_addr !== 64'h4) begin
      n_err++; $display("FAIL lat3_ack got en=%0b v=%0b pc=%0h addr=%0h want 1/1/0/4", obs_en, id_valid, id_pc, imem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h0));
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h4));
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h0, mem_f(64'h8));
    n_chk++; if (obs_en !== 1'b0 || imem_req !== 1'b0 || id_pc !== 64'h4 || id_valid !== 1'b1) begin
      n_err++; $display("FAIL stall_enter got en=%0b req=%0b pc=%0h want 0/0/4", obs_en, imem_req, id_pc); end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 32'h0);
      n_chk++; if (obs_en !== 1'b0 || imem_req !== 1'b0 || id_pc !== 64'h4 || id_instr !== mem_f(64'h4)) begin
        n_err++; $display("FAIL stall_hold%0d got en=%0b req=%0b pc=%0h want 0/0/4", k, obs_en, imem_req, id_pc); end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    n_chk++; if (obs_en !== 1'b1 || obs_nxt !== 64'hC) begin
      n_err++; $display("FAIL stall_release_pc got=%0b/%0h want=1/c", obs_en, obs_nxt); end
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instr !== mem_f(64'h8) || imem_req !== 1'b1 || imem_addr !== 64'hC) begin
      n_err++; $display("FAIL stall_release got pc=%0h instr=%0h req=%0b addr=%0h want 8/%0h/1/c", id_pc, id_instr, imem_req, imem_addr, mem_f(64'h8)); end
  endtask

  task automatic test_flush_ack();
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h0));
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'h100, mem_f(64'h4));
    n_chk++; if (obs_en !== 1'b1 || obs_nxt !== 64'h100) begin
      n_err++; $display("FAIL flush_ack_pc got=%0b/%0h want=1/100", obs_en, obs_nxt); end
    n_chk++; if (id_valid !== 1'b0 || id_instr !== NOPV || imem_addr !== 64'h100 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL flush_ack got v=%0b instr=%0h addr=%0h req=%0b want 0/13/100/1", id_valid, id_instr, imem_addr, imem_req); end
  endtask

  task automatic test_flush_mid();
    do_reset();
    for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'(4 * k)));
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 32'h0);
    n_chk++; if (obs_en !== 1'b1 || obs_nxt !== 64'h100) begin
      n_err++; $display("FAIL flush_mid_pc got=%0b/%0h want=1/100", obs_en, obs_nxt); end
    n_chk++; if (imem_addr !== 64'h20 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_mid_hold got addr=%0h req=%0b v=%0b want 20/1/0", imem_addr, imem_req, id_valid); end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    n_chk++; if (obs_en !== 1'b0 || imem_addr !== 64'h20) begin
      n_err++; $display("FAIL flush_mid_wait got en=%0b addr=%0h want 0/20", obs_en, imem_addr); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h20));
    n_chk++; if (obs_en !== 1'b0 || imem_addr !== 64'h100 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_mid_drop got en=%0b addr=%0h v=%0b want 0/100/0", obs_en, imem_addr, id_valid); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h100));
    n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== mem_f(64'h100)) begin
      n_err++; $display("FAIL flush_mid_target got v=%0b pc=%0h want 1/100", id_valid, id_pc); end
  endtask

  task automatic test_reset_mid_and_priority();
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h80, 32'h1234);
    n_chk++; if (obs_en !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h0 || id_valid !== 1'b0 || id_instr !== NOPV) begin
      n_err++; $display("FAIL rst_mid got en=%0b req=%0b addr=%0h v=%0b want 0/0/0/0", obs_en, imem_req, imem_addr, id_valid); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 32'h5555);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 64'h0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ack_ignored got req=%0b addr=%0h v=%0b want 1/0/0", imem_req, imem_addr, id_valid); end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, mem_f(64'h0));
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 64'h200, mem_f(64'h4));
    n_chk++; if (obs_en !== 1'b1 || obs_nxt !== 64'h200 || id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      n_err++; $display("FAIL flush_stall got en=%0b v=%0b req=%0b addr=%0h want 1/0/1/200", obs_en, id_valid, imem_req, imem_addr); end
  endtask

  task automatic test_random(input int ncyc);
    int cnt, lat, bad;
    logic a, f, s, r, busy;
    logic [63:0] t;
    bad = 0;
    do_reset();
    cnt = 0;
    lat = $urandom_range(1, 3);
    for (int i = 0; i < ncyc; i++) begin
      busy = m_started && !m_held;
      if (busy) begin
        cnt++;
        a = (cnt >= lat);
        if (a) begin cnt = 0; lat = $urandom_range(1, 3); end
      end else begin
        cnt = 0;
        a = ($urandom_range(0, 9) == 0);
      end
      r = ($urandom_range(0, 399) == 0);
      f = m_started && ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : ({$urandom, $urandom} & ~64'h3);
      drive_cycle(r, a, f, s, t, $urandom);
      n_chk++; if (obs_en !== exp_en || (exp_en && obs_nxt !== exp_nxt)) begin
        n_err++; bad++;
        if (bad < 10) $display("FAIL rnd_pc cyc=%0d got=%0b/%0h want=%0b/%0h", i, obs_en, obs_nxt, exp_en, exp_nxt); end
      n_chk++; if (imem_req !== (m_started && !m_held) || imem_addr !== m_addr) begin
        n_err++; bad++;
        if (bad < 10) $display("FAIL rnd_imem cyc=%0d got=%0b/%0h want=%0b/%0h", i, imem_req, imem_addr, m_started && !m_held, m_addr); end
      n_chk++; if (id_valid !== m_v || id_pc !== m_pc || id_instr !== m_ins) begin
        n_err++; bad++;
        if (bad < 10) $display("FAIL rnd_id cyc=%0d got=%0b/%0h/%0h want=%0b/%0h/%0h", i, id_valid, id_pc, id_instr, m_v, m_pc, m_ins); end
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
    flush_target = '0; imem_rdata = '0;
    m_started = 1'b0; m_held = 1'b0; m_drop = 1'b0; m_addr = '0; m_redir = '0;
    m_bpc = '0; m_binstr = '0; m_v = 1'b0; m_pc = '0; m_ins = NOPV;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_latency3();
    test_stall();
    test_flush_ack();
    test_flush_mid();
    test_reset_mid_and_priority();
    test_random(4000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
